// File: rtl/eth_rx_mac_gen.sv
// Ethernet receive MAC front end for 1/2/4/8-bit PHY lanes: SFD hunt, LSB-first
// byte assembly, FCS check, optional FCS strip via a delay line, per-frame status.
module eth_rx_mac_gen #(
    parameter int DATA_WIDTH    = 8,
    parameter int ENABLE_CRC    = 1,
    parameter int STRIP_FCS     = 1,
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_dv,
    input  logic                  rx_er,
    input  logic [DATA_WIDTH-1:0] rxd,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic                  m_tuser,
    output logic                  status_valid,
    output logic [15:0]           frame_length,
    output logic                  crc_ok,
    output logic                  err_preamble,
    output logic                  err_runt,
    output logic                  err_giant,
    output logic                  err_crc,
    output logic                  err_phy,
    output logic                  err_align
);
    localparam int          BEATS       = 8 / DATA_WIDTH;
    localparam int          DEPTH       = (STRIP_FCS != 0) ? 5 : 1;
    localparam logic [2:0]  LANE_LAST   = 3'(BEATS - 1);
    localparam logic [2:0]  DEPTH_L     = 3'(DEPTH);
    localparam logic [7:0]  PRE_LIMIT   = 8'(72 / DATA_WIDTH);
    localparam logic [16:0] MIN_L       = 17'(MIN_FRAME_LEN);
    localparam logic [16:0] MAX_L       = 17'(MAX_FRAME_LEN);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state_q;
    logic        dv_prev_q;
    logic [7:0]  sr_q;
    logic [2:0]  lane_cnt_q;
    logic [7:0]  pre_cnt_q;
    logic [15:0] byte_cnt_q;
    logic [31:0] crc_q;
    logic [7:0]  dly_q [DEPTH];
    logic [2:0]  dly_cnt_q;
    logic        err_pre_q, err_giant_q, err_phy_q;

    logic [7:0]  sr_d, sr_start;
    logic [31:0] crc_d;
    logic        crc_match, crc_ok_w, end_align, end_runt, end_crc, end_bad;
    logic [15:0] len_w;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // New lane bits enter at the top so the first-received bits end up in the low byte bits.
    generate
        if (DATA_WIDTH == 8) begin : g_full
            logic unused_sr;
            assign unused_sr = ^sr_q;
            assign sr_d      = rxd;
            assign sr_start  = rxd;
        end else begin : g_lane
            assign sr_d     = {rxd, sr_q[7:DATA_WIDTH]};
            assign sr_start = {rxd, {(8 - DATA_WIDTH){1'b0}}};
        end
    endgenerate

    assign crc_d     = crc_byte(crc_q, sr_d);
    assign crc_match = (crc_q == CRC_RESIDUE);
    assign crc_ok_w  = (ENABLE_CRC == 0) || crc_match;
    assign end_align = (lane_cnt_q != 3'd0);
    assign end_runt  = ({1'b0, byte_cnt_q} < MIN_L);
    assign end_crc   = (ENABLE_CRC != 0) && !crc_match;
    assign end_bad   = end_align | end_runt | end_crc | err_phy_q;
    assign len_w     = (byte_cnt_q > 16'd4) ? (byte_cnt_q - 16'd4) : 16'd0;

    // m_tvalid is a one-cycle strobe per byte with no ready: downstream must take every beat;
    // m_tuser is only meaningful alongside m_tlast, status fields only alongside status_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dv_prev_q    <= 1'b1;
            sr_q         <= '0;
            lane_cnt_q   <= '0;
            pre_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            crc_q        <= CRC_INIT;
            dly_cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
            err_pre_q    <= 1'b0;
            err_giant_q  <= 1'b0;
            err_phy_q    <= 1'b0;
            m_tdata      <= '0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            m_tuser      <= 1'b0;
            status_valid <= 1'b0;
            frame_length <= '0;
            crc_ok       <= 1'b0;
            err_preamble <= 1'b0;
            err_runt     <= 1'b0;
            err_giant    <= 1'b0;
            err_crc      <= 1'b0;
            err_phy      <= 1'b0;
            err_align    <= 1'b0;
        end else begin
            dv_prev_q    <= rx_dv;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            m_tuser      <= 1'b0;
            status_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_dv && !dv_prev_q) begin
                        sr_q        <= sr_start;
                        pre_cnt_q   <= 8'd1;
                        byte_cnt_q  <= '0;
                        crc_q       <= CRC_INIT;
                        dly_cnt_q   <= '0;
                        err_pre_q   <= 1'b0;
                        err_giant_q <= 1'b0;
                        err_phy_q   <= 1'b0;
                        state_q     <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (!rx_dv) begin
                        status_valid <= 1'b1;
                        frame_length <= '0;
                        crc_ok       <= crc_ok_w;
                        err_preamble <= 1'b1;
                        err_runt     <= 1'b0;
                        err_giant    <= 1'b0;
                        err_crc      <= 1'b0;
                        err_phy      <= 1'b0;
                        err_align    <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        sr_q      <= sr_d;
                        pre_cnt_q <= pre_cnt_q + 8'd1;
                        if (sr_d == 8'hD5) begin
                            lane_cnt_q <= '0;
                            byte_cnt_q <= '0;
                            crc_q      <= CRC_INIT;
                            state_q    <= DATA;
                        end else if (pre_cnt_q >= PRE_LIMIT) begin
                            err_pre_q <= 1'b1;
                            state_q   <= DROP;
                        end
                    end
                end
                DATA: begin
                    if (!rx_dv) begin
                        if (dly_cnt_q == DEPTH_L) begin
                            m_tdata  <= dly_q[DEPTH-1];
                            m_tvalid <= 1'b1;
                            m_tlast  <= 1'b1;
                            m_tuser  <= end_bad;
                        end
                        dly_cnt_q    <= '0;
                        status_valid <= 1'b1;
                        frame_length <= len_w;
                        crc_ok       <= crc_ok_w;
                        err_preamble <= 1'b0;
                        err_runt     <= end_runt;
                        err_giant    <= 1'b0;
                        err_crc      <= end_crc;
                        err_phy      <= err_phy_q;
                        err_align    <= end_align;
                        state_q      <= IDLE;
                    end else begin
                        sr_q <= sr_d;
                        if (rx_er) err_phy_q <= 1'b1;
                        if (lane_cnt_q == LANE_LAST) begin
                            lane_cnt_q <= '0;
                            if (({1'b0, byte_cnt_q} + 17'd1) > MAX_L) begin
                                // Oversize byte closes the output frame as bad and is not stored.
                                if (dly_cnt_q == DEPTH_L) begin
                                    m_tdata  <= dly_q[DEPTH-1];
                                    m_tvalid <= 1'b1;
                                    m_tlast  <= 1'b1;
                                    m_tuser  <= 1'b1;
                                end
                                dly_cnt_q   <= '0;
                                err_giant_q <= 1'b1;
                                state_q     <= DROP;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 16'd1;
                                crc_q      <= crc_d;
                                dly_q[0]   <= sr_d;
                                for (int i = 1; i < DEPTH; i++) dly_q[i] <= dly_q[i-1];
                                if (dly_cnt_q == DEPTH_L) begin
                                    m_tdata  <= dly_q[DEPTH-1];
                                    m_tvalid <= 1'b1;
                                end else begin
                                    dly_cnt_q <= dly_cnt_q + 3'd1;
                                end
                            end
                        end else begin
                            lane_cnt_q <= lane_cnt_q + 3'd1;
                        end
                    end
                end
                DROP: begin
                    if (!rx_dv) begin
                        status_valid <= 1'b1;
                        frame_length <= len_w;
                        crc_ok       <= crc_ok_w;
                        err_preamble <= err_pre_q;
                        err_runt     <= 1'b0;
                        err_giant    <= err_giant_q;
                        err_crc      <= err_giant_q & end_crc;
                        err_phy      <= err_phy_q;
                        err_align    <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
